// File: rtl/cbrt_pkg.sv
// Shared constants and state encoding for the cbrt iterative cube-root unit.
// Imported by cbrt_if, cbrt_mul and cbrt.
package cbrt_pkg;
  localparam int X_W        = 24;
  localparam int Y_W        = 8;
  localparam int P_W        = 2 * Y_W;
  localparam int B_W        = P_W + 2;
  localparam int S_W        = 5;
  localparam int ITERATIONS = 8;
  localparam int MUL_CYCLES = 8;
  localparam int S_INIT     = 3 * (ITERATIONS - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MUL_START = 2'd1,
    MUL_WAIT  = 2'd2,
    STEP      = 2'd3
  } state_t;
endpackage

// File: rtl/cbrt_if.sv
// Request/result bundle between a cbrt client (master) and the unit (slave).
// rem_bo exists only when CBRT_REMAINDER_EN is defined.
interface cbrt_if;
  import cbrt_pkg::*;

  logic           start_i;
  logic [X_W-1:0] a_bi;
  logic           busy_o;
  logic [Y_W-1:0] y_bo;
`ifdef CBRT_REMAINDER_EN
  logic [X_W-1:0] rem_bo;

  modport master (output start_i, output a_bi, input busy_o, input y_bo, input rem_bo);
  modport slave  (input start_i, input a_bi, output busy_o, output y_bo, output rem_bo);
`else
  modport master (output start_i, output a_bi, input busy_o, input y_bo);
  modport slave  (input start_i, input a_bi, output busy_o, output y_bo);
`endif
endinterface

// File: rtl/cbrt_mul.sv
// Sequential shift-add 8x8->16 multiplier; first partial product on the start edge,
// busy_o drops after 7 more edges so the product is valid 8 cycles after start.
module cbrt_mul
  import cbrt_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [Y_W-1:0] a_bi,
  input  logic [Y_W-1:0] b_bi,
  input  logic           start_i,
  output logic           busy_o,
  output logic [P_W-1:0] y_bo
);
  logic [P_W-1:0] r_acc;
  logic [P_W-1:0] r_mc;
  logic [Y_W-1:0] r_mp;
  logic [2:0]     r_cnt;
  logic           r_busy;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_acc  <= '0;
      r_mc   <= '0;
      r_mp   <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (start_i && !r_busy) begin
      r_acc  <= b_bi[0] ? P_W'(a_bi) : '0;
      r_mc   <= P_W'(a_bi) << 1;
      r_mp   <= b_bi >> 1;
      r_cnt  <= 3'd1;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      if (r_mp[0]) r_acc <= r_acc + r_mc;
      r_mc  <= r_mc << 1;
      r_mp  <= r_mp >> 1;
      r_cnt <= r_cnt + 3'd1;
      if (r_cnt == 3'(MUL_CYCLES - 1)) r_busy <= 1'b0;
    end
  end

  assign busy_o = r_busy;
  assign y_bo   = r_acc;
endmodule

// File: rtl/cbrt.sv
// Digit-recurrence floor cube root, one result bit per 10-cycle iteration (80 cycles total,
// zero operand completes on the accepting edge). start_i is ignored while busy. Macro: CBRT_REMAINDER_EN.
module cbrt
  import cbrt_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_i,
  cbrt_if.slave bus
);
  state_t         r_state, w_state_nxt;
  logic [X_W-1:0] r_x, w_x_nxt;
  logic [Y_W-1:0] r_y, w_y_nxt;
  logic [S_W-1:0] r_s, w_s_nxt;
  logic [Y_W-1:0] r_y_out, w_y_out_nxt;
`ifdef CBRT_REMAINDER_EN
  logic [X_W-1:0] r_rem, w_rem_nxt;
`endif

  logic [Y_W-1:0] w_y2, w_y2p1, w_y_new;
  logic [P_W-1:0] w_prod;
  logic [B_W-1:0] w_b;
  logic [X_W-1:0] w_xs, w_bs, w_x_new;
  logic           w_fit, w_mul_busy;

  assign w_y2   = r_y << 1;
  assign w_y2p1 = w_y2 | Y_W'(1);

  cbrt_mul u_mul (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .a_bi    (w_y2),
    .b_bi    (w_y2p1),
    .start_i (r_state == MUL_START),
    .busy_o  (w_mul_busy),
    .y_bo    (w_prod)
  );

  // b = 3*y2*(y2+1) + 1; compare against x>>s so nothing grows past 24 bits
  assign w_b     = (B_W'(w_prod) << 1) + B_W'(w_prod) + B_W'(1);
  assign w_xs    = r_x >> r_s;
  assign w_fit   = w_xs >= X_W'(w_b);
  assign w_bs    = X_W'(w_b) << r_s;
  assign w_y_new = w_fit ? w_y2p1 : w_y2;
  assign w_x_new = w_fit ? (r_x - w_bs) : r_x;

  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_s_nxt     = r_s;
    w_y_out_nxt = r_y_out;
`ifdef CBRT_REMAINDER_EN
    w_rem_nxt   = r_rem;
`endif
    case (r_state)
      IDLE: begin
        if (bus.start_i) begin
          if (bus.a_bi != '0) begin
            w_x_nxt     = bus.a_bi;
            w_y_nxt     = '0;
            w_s_nxt     = S_W'(S_INIT);
            w_state_nxt = MUL_START;
          end else begin
            w_y_out_nxt = '0;
`ifdef CBRT_REMAINDER_EN
            w_rem_nxt   = '0;
`endif
          end
        end
      end
      MUL_START: w_state_nxt = MUL_WAIT;
      MUL_WAIT:  if (!w_mul_busy) w_state_nxt = STEP;
      STEP: begin
        w_x_nxt = w_x_new;
        w_y_nxt = w_y_new;
        if (r_s == '0) begin
          w_y_out_nxt = w_y_new;
`ifdef CBRT_REMAINDER_EN
          w_rem_nxt   = w_x_new;
`endif
          w_state_nxt = IDLE;
        end else begin
          w_s_nxt     = r_s - S_W'(3);
          w_state_nxt = MUL_START;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_s     <= '0;
      r_y_out <= '0;
`ifdef CBRT_REMAINDER_EN
      r_rem   <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_s     <= w_s_nxt;
      r_y_out <= w_y_out_nxt;
`ifdef CBRT_REMAINDER_EN
      r_rem   <= w_rem_nxt;
`endif
    end
  end

  assign bus.busy_o = (r_state != IDLE);
  assign bus.y_bo   = r_y_out;
`ifdef CBRT_REMAINDER_EN
  assign bus.rem_bo = r_rem;
`endif
endmodule

// File: tb/tb_cbrt.sv
// Bench for cbrt: latency-level reference model checked every cycle plus directed literal vectors.
// Remainder checks are active when CBRT_REMAINDER_EN is defined.
module tb_cbrt;
  logic clk;
  logic rst;
  cbrt_if bus();

  cbrt dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint cbrt_ref(input longint a);
    longint n;
    n = 0;
    while ((n + 1) * (n + 1) * (n + 1) <= a) n++;
    return n;
  endfunction

  // Reference: result appears 80 edges after acceptance, zero operand resolves on the accepting edge
  int     m_cnt;
  longint m_a;
  logic   exp_busy;
  longint exp_y;
  longint exp_rem;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt    <= 0;
      m_a      <= 0;
      exp_busy <= 1'b0;
      exp_y    <= 0;
      exp_rem  <= 0;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        exp_busy <= 1'b0;
        exp_y    <= cbrt_ref(m_a);
        exp_rem  <= m_a - cbrt_ref(m_a) * cbrt_ref(m_a) * cbrt_ref(m_a);
      end
    end else if (bus.start_i) begin
      if (bus.a_bi == '0) begin
        exp_y   <= 0;
        exp_rem <= 0;
      end else begin
        m_cnt    <= 80;
        m_a      <= longint'(bus.a_bi);
        exp_busy <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("cyc_busy", longint'(bus.busy_o), longint'(exp_busy));
      chk("cyc_y", longint'(bus.y_bo), exp_y);
`ifdef CBRT_REMAINDER_EN
      chk("cyc_rem", longint'(bus.rem_bo), exp_rem);
`endif
    end
  end

  // Called #1 after an edge; returns #1 after the completion edge
  task automatic do_op(input logic [23:0] a, input longint ey, input longint erem,
                       input int pc, input logic [23:0] pa);
    int w;
    w = 0;
    bus.start_i = 1'b1;
    bus.a_bi    = a;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    while (bus.busy_o && w < 200) begin
      @(posedge clk);
      #1;
      w++;
      if (pc != 0) begin
        if (w == pc) begin
          bus.start_i = 1'b1;
          bus.a_bi    = pa;
        end else if (w == pc + 1) begin
          bus.start_i = 1'b0;
        end
      end
    end
    chk("busy_width", longint'(w), (a == 24'd0) ? 0 : 80);
    chk("y_lit", longint'(bus.y_bo), ey);
`ifdef CBRT_REMAINDER_EN
    chk("rem_lit", longint'(bus.rem_bo), erem);
`else
    if (erem < 0) chk("rem_arg", erem, 0);
`endif
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not end, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    longint c;
    rst         = 1'b1;
    bus.start_i = 1'b0;
    bus.a_bi    = '0;
    #12;
    chk("rst_busy", longint'(bus.busy_o), 0);
    chk("rst_y", longint'(bus.y_bo), 0);
`ifdef CBRT_REMAINDER_EN
    chk("rst_rem", longint'(bus.rem_bo), 0);
`endif
    rst = 1'b0;
    @(posedge clk);
    #1;

    do_op(24'd27, 3, 0, 0, 24'd0);
    do_op(24'd26, 2, 18, 0, 24'd0);
    do_op(24'd16777215, 255, 195840, 0, 24'd0);
    do_op(24'd16581375, 255, 0, 0, 24'd0);
    do_op(24'd27, 3, 0, 0, 24'd0);

    // Abort a long run with an asynchronous reset between edges
    bus.start_i = 1'b1;
    bus.a_bi    = 24'd1000000;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    repeat (39) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_busy", longint'(bus.busy_o), 0);
    chk("arst_y", longint'(bus.y_bo), 0);
`ifdef CBRT_REMAINDER_EN
    chk("arst_rem", longint'(bus.rem_bo), 0);
`endif
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    do_op(24'd27, 3, 0, 0, 24'd0);

    do_op(24'd0, 0, 0, 0, 24'd0);
    // Start pulsed mid-run is ignored, then an immediate restart is accepted
    do_op(24'd1000000, 100, 0, 30, 24'd8);
    do_op(24'd27, 3, 0, 0, 24'd0);
    do_op(24'd0, 0, 0, 0, 24'd0);

    for (int n = 0; n < 256; n++) begin
      c = longint'(n) * n * n;
      do_op(24'(c), longint'(n), 0, 0, 24'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule

// File: doc/cbrt.md
# cbrt

Iterative integer cube-root unit: it accepts a 24-bit unsigned operand and returns floor(cbrt(x)) as 8 bits. It sits directly downstream of the 8-bit cube stage and consumes that stage's 24-bit y_bo result, so a cube→cbrt chain must reproduce the original operand. It is built around a digit-recurrence loop, one result bit per iteration, using a small sequential 8x8 multiplier.

## Interface
- No parameters; widths are fixed by the cube stage (24-bit in, 8-bit out).
- clk_i  input  1  single clock; all state updates on the rising edge.
- rst_i  input  1  reset, asynchronous, active-high; clears all state immediately.
- start_i  input  1  request; sampled only while idle.
- a_bi  input  24  unsigned radicand; sampled on the edge that accepts start_i.
- busy_o  output  1  high while a computation is in progress.
- y_bo  output  8  floor cube root; holds the last result until the next completion.
- rem_bo  output  24  remainder a - y^3; present only with CBRT_REMAINDER_EN.

## Operation
- Registers: x (24-bit working remainder), y (8-bit partial root), s (shift: 21, 18, ..., 0), state.
- States: IDLE, MUL_START, MUL_WAIT, STEP.
- IDLE: on start_i=1 with a_bi≠0: x←a_bi, y←0, s←21, busy_o←1, go to MUL_START.
- IDLE: on start_i=1 with a_bi=0: y_bo←0 (and rem_bo←0) on the same edge; busy_o stays 0; remain in IDLE.
- MUL_START: y2=y<<1; launch multiplier with y2 and y2+1 (both ≤255, so they fit 8 bits); go to MUL_WAIT.
- MUL_WAIT: stay until the multiplier signals done (product p is 16 bits, at most 64770), then go to STEP.
- STEP: b=3·p+1 (18 bits). If (x>>s) ≥ b: x←x−(b<<s), y←y2+1. Otherwise y←y2.
- STEP, s=0: load y_bo with the new y (and rem_bo with the new x), busy_o←0, go to IDLE.
- STEP, s≠0: s←s−3, go to MUL_START.
- Arithmetic is unsigned. The comparison uses x>>s, so no intermediate exceeds 24 bits. The subtraction never underflows.
- start_i while busy_o=1 is ignored; a_bi is not re-sampled.
- Reset mid-operation aborts the computation; outputs return to reset values.

## Timing
- Reset values: busy_o=0, y_bo=0, rem_bo=0, state=IDLE.
- Multiplier: accepts start in MUL_START; done is valid after exactly 8 cycles in MUL_WAIT.
- Per iteration: 1 (MUL_START) + 8 (MUL_WAIT) + 1 (STEP) = 10 cycles. There are 8 iterations.
- Latency: busy_o rises on the edge that accepts start_i and falls exactly 80 edges later.
- y_bo updates on that same final edge.
- Back-to-back operation: start_i may be high on the edge right after busy_o falls; it is accepted there.
- Zero operand: latency 0, with y_bo=0 after the sampling edge.

## Configuration
- CBRT_REMAINDER_EN defined: rem_bo port exists and carries the final x (a−y^3). It is cleared by reset and written on completion.
- Not defined: rem_bo port is absent. The x register is still required internally; no other behaviour changes.

## Structure
- Shared package cbrt_pkg holds:
  - state encoding (IDLE=0, MUL_START=1, MUL_WAIT=2, STEP=3);
  - width constants X_W=24, Y_W=8;
  - ITERATIONS=8;
  - MUL_CYCLES=8;
  - initial shift S_INIT=21.
- One sub-module, cbrt_mul: sequential shift-add 8x8→16 multiplier with clk_i, rst_i, a_bi, b_bi, start_i, busy_o, y_bo, and fixed 8-cycle latency.

## Test plan
- Reset asserted asynchronously between clock edges mid-computation (input 1000000, cycle 40) → busy_o, y_bo, rem_bo are 0 immediately; a later start of 27 yields y_bo=3.
- a_bi=27 → after 80 cycles y_bo=3, rem_bo=0. a_bi=26 → y_bo=2, rem_bo=18.
- a_bi=16777215 → y_bo=255, rem_bo=195840. a_bi=16581375 → y_bo=255, rem_bo=0.
- a_bi=0 → y_bo=0 on the next edge; busy_o never rises.
- start_i pulsed at cycle 30 of a 1000000 run with a_bi=8 → ignored; result is y_bo=100. Immediate restart on the completion+1 edge is accepted.
- Exhaustive chain check: the cube stage output for every 8-bit n is fed in → y_bo=n, rem_bo=0; busy_o width is exactly 80 cycles for every nonzero input.
